// File: rtl/cam_stream_gen.sv
// rtl/cam_stream_gen.sv - synthetic vsync/href/RGB565 camera stream generator
// Optional feature macro: CAM_STREAM_LFSR_EN (builds the LFSR and pattern 3;
// the LFSR_SEED parameter exists only in that build).
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   enable            run frames back to back while high
//   pattern_sel[1:0]  0 solid, 1 ramp, 2 checker, 3 LFSR; latched at frame start
//   vsync             frame-start pulse, VSYNC_CYCLES wide
//   href              line-active qualifier, IMG_WIDTH cycles per line
//   pixel_data[15:0]  RGB565 pixel, zero whenever href is low
//   frame_done        one-cycle pulse on the first vertical-blanking cycle
//   busy              high whenever the generator is not idle
//   frame_count[15:0] completed frames, wrapping
module cam_stream_gen #(
  parameter int          IMG_WIDTH     = 64,
  parameter int          IMG_HEIGHT    = 48,
  parameter int          VSYNC_CYCLES  = 2,
  parameter int          HBLANK_CYCLES = 2,
  parameter int          VBLANK_CYCLES = 4,
  parameter logic [15:0] SOLID_COLOR   = 16'hF800
`ifdef CAM_STREAM_LFSR_EN
  ,
  parameter logic [31:0] LFSR_SEED     = 32'h1BADB002
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        vsync,
  output logic        href,
  output logic [15:0] pixel_data,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0] VS_LAST  = 16'(VSYNC_CYCLES - 1);
  localparam logic [15:0] HB_LAST  = 16'(HBLANK_CYCLES - 1);
  localparam logic [15:0] VB_LAST  = 16'(VBLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  state_t      state, state_nx;
  logic [15:0] col, row, tcnt;
  logic [1:0]  pat_q;
  logic [15:0] pix_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (enable) state_nx = S_VSYNC;
      S_VSYNC:  if (tcnt == VS_LAST) state_nx = S_ACTIVE;
      S_ACTIVE: if (col == LAST_COL) state_nx = S_HBLANK;
      S_HBLANK: if (tcnt == HB_LAST) state_nx = (row == LAST_ROW) ? S_VBLANK : S_ACTIVE;
      // enable is only consulted here, so a frame in flight always completes.
      S_VBLANK: if (tcnt == VB_LAST) state_nx = enable ? S_VSYNC : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // tcnt measures time spent in the current sync/blanking state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      col  <= '0;
      row  <= '0;
    end else begin
      if (state_nx != state)
        tcnt <= '0;
      else if (state == S_VSYNC || state == S_HBLANK || state == S_VBLANK)
        tcnt <= tcnt + 16'd1;

      if (state == S_ACTIVE)
        col <= (state_nx == S_ACTIVE) ? col + 16'd1 : '0;
      else if (state_nx == S_ACTIVE)
        col <= '0;

      if (state == S_VSYNC && state_nx == S_ACTIVE)
        row <= '0;
      else if (state == S_HBLANK && state_nx == S_ACTIVE)
        row <= row + 16'd1;
    end
  end

  // The pattern is captured on entry to VSYNC so a frame is never mixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pat_q <= 2'd0;
    else if (state_nx == S_VSYNC && state != S_VSYNC)
      pat_q <= pattern_sel;
  end

`ifdef CAM_STREAM_LFSR_EN
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  logic [31:0] lfsr;

  // Free-running across frames; only reset reloads the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= SEED_EFF;
    else if (state == S_ACTIVE && pat_q == 2'd3)
      lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
  end
`endif

  always_comb begin
    pix_c = 16'h0000;
    case (pat_q)
      2'd0: pix_c = SOLID_COLOR;
      2'd1: pix_c = {col[7:3], col[7:2], col[7:3]};
      2'd2: pix_c = (col[3] ^ row[3]) ? 16'hFFFF : 16'h0000;
      default: begin
`ifdef CAM_STREAM_LFSR_EN
        pix_c = lfsr[15:0];
`else
        pix_c = 16'h0000;
`endif
      end
    endcase
  end

  // Outputs are registered from the current state, so the visible stream
  // trails the state register by one clock; all outputs share that delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync       <= 1'b0;
      href        <= 1'b0;
      pixel_data  <= 16'h0000;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      vsync      <= (state == S_VSYNC);
      href       <= (state == S_ACTIVE);
      pixel_data <= (state == S_ACTIVE) ? pix_c : 16'h0000;
      busy       <= (state != S_IDLE);
      frame_done <= (state == S_VBLANK && tcnt == 16'd0);
      if (state == S_VBLANK && tcnt == 16'd0)
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule
